// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of one single-ported unified memory.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-port priority.
module mem_arbiter #(
  parameter int unsigned           ADDR_W    = 32,
  parameter int unsigned           DATA_W    = 32,
  parameter logic [ADDR_W-1:0]     IM_OFFSET = '0,
  parameter logic [ADDR_W-1:0]     DM_OFFSET = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              im_en_i,
  input  logic [ADDR_W-1:0] im_addr_i,
  output logic [DATA_W-1:0] im_dout_o,
  output logic              im_busy_o,
  input  logic              dm_en_i,
  input  logic              dm_wen_i,
  input  logic [DATA_W-1:0] dm_din_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  output logic [DATA_W-1:0] dm_dout_o,
  output logic              dm_busy_o,
  output logic              mem_en_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  input  logic              mem_busy_i
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT_IM = 3'd1;
  localparam logic [2:0] GNT_DM = 3'd2;
  localparam logic [2:0] RSP_IM = 3'd3;
  localparam logic [2:0] RSP_DM = 3'd4;

  logic [2:0]        state, state_nxt;
  logic              mem_en_nxt, mem_wen_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_din_nxt, im_dout_nxt, dm_dout_nxt;
  logic              arb_open, arb_req, arb_dm, mem_done;

  assign arb_open = (state == IDLE) || (state == RSP_IM) || (state == RSP_DM);
  assign arb_req  = im_en_i | dm_en_i;
  assign mem_done = mem_en_o & ~mem_busy_i;

  assign im_busy_o = im_en_i & (state != RSP_IM);
  assign dm_busy_o = dm_en_i & (state != RSP_DM);

`ifdef MEM_ARB_RR_EN
  // last_dm: 1 = data port granted last; reset to dm so im wins the first tie
  logic last_dm;

  assign arb_dm = dm_en_i & (~im_en_i | ~last_dm);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_dm <= 1'b1;
    end else if (arb_open && arb_req) begin
      last_dm <= arb_dm;
    end
  end
`else
  assign arb_dm = dm_en_i;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    mem_en_nxt   = mem_en_o;
    mem_wen_nxt  = mem_wen_o;
    mem_addr_nxt = mem_addr_o;
    mem_din_nxt  = mem_din_o;
    im_dout_nxt  = im_dout_o;
    dm_dout_nxt  = dm_dout_o;
    case (state)
      IDLE, RSP_IM, RSP_DM: begin
        state_nxt = IDLE;
        if (arb_req) begin
          mem_en_nxt = 1'b1;
          if (arb_dm) begin
            state_nxt    = GNT_DM;
            mem_addr_nxt = dm_addr_i + DM_OFFSET;
            mem_din_nxt  = dm_din_i;
            mem_wen_nxt  = dm_wen_i;
          end else begin
            state_nxt    = GNT_IM;
            mem_addr_nxt = im_addr_i + IM_OFFSET;
            mem_wen_nxt  = 1'b0;
          end
        end
      end
      GNT_IM: begin
        if (mem_done) begin
          state_nxt   = RSP_IM;
          mem_en_nxt  = 1'b0;
          im_dout_nxt = mem_dout_i;
        end
      end
      GNT_DM: begin
        if (mem_done) begin
          state_nxt  = RSP_DM;
          mem_en_nxt = 1'b0;
          if (!mem_wen_o) begin
            dm_dout_nxt = mem_dout_i;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        mem_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      mem_en_o   <= 1'b0;
      mem_wen_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_din_o  <= '0;
      im_dout_o  <= '0;
      dm_dout_o  <= '0;
    end else begin
      state      <= state_nxt;
      mem_en_o   <= mem_en_nxt;
      mem_wen_o  <= mem_wen_nxt;
      mem_addr_o <= mem_addr_nxt;
      mem_din_o  <= mem_din_nxt;
      im_dout_o  <= im_dout_nxt;
      dm_dout_o  <= dm_dout_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam logic [31:0] DM_OFF = 32'hFFFF_FFF0;
`ifdef MEM_ARB_RR_EN
  localparam int EXP_IM_RSP = 3;
  localparam int EXP_DM_RSP = 3;
`else
  localparam int EXP_IM_RSP = 0;
  localparam int EXP_DM_RSP = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_en = 1'b0;
  logic [31:0] im_addr = '0;
  logic [31:0] im_dout_o;
  logic        im_busy_o;
  logic        dm_en = 1'b0;
  logic        dm_wen = 1'b0;
  logic [31:0] dm_din = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_dout_o;
  logic        dm_busy_o;
  logic        mem_en_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout = '0;
  logic        mem_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .IM_OFFSET(32'h0), .DM_OFFSET(DM_OFF)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_en_i(im_en), .im_addr_i(im_addr), .im_dout_o(im_dout_o), .im_busy_o(im_busy_o),
    .dm_en_i(dm_en), .dm_wen_i(dm_wen), .dm_din_i(dm_din), .dm_addr_i(dm_addr),
    .dm_dout_o(dm_dout_o), .dm_busy_o(dm_busy_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout), .mem_busy_i(mem_busy)
  );

  typedef struct {
    logic        im_en;
    logic [31:0] im_addr;
    logic        dm_en;
    logic        dm_wen;
    logic [31:0] dm_din;
    logic [31:0] dm_addr;
    logic        mem_busy;
    logic [31:0] mem_dout;
    logic        x_en;
    logic        x_wen;
    logic [31:0] x_addr;
    logic        x_imb;
    logic        x_dmb;
    logic [31:0] x_imd;
    logic [31:0] x_dmd;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int im_rsp;
    int dm_rsp;

    // im fetch, dm write with 3 wait cycles, wrapped dm read, im en dropped while granted
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13,
                 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13,
                 1'b1, 1'b0, 32'h100,  1'b1, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13,
                 1'b0, 1'b0, 32'h100,  1'b0, 1'b0, 32'h13, 32'h0};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h2000, 1'b1, 32'h13,
                 1'b0, 1'b0, 32'h100,  1'b0, 1'b1, 32'h13, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h2000, 1'b1, 32'h13,
                 1'b1, 1'b1, 32'h1FF0, 1'b0, 1'b1, 32'h13, 32'h0};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h2000, 1'b0, 32'h55555555,
                 1'b1, 1'b1, 32'h1FF0, 1'b0, 1'b1, 32'h13, 32'h0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h2000, 1'b0, 32'h55555555,
                 1'b0, 1'b1, 32'h1FF0, 1'b0, 1'b0, 32'h13, 32'h0};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h20, 1'b0, 32'hA5A50001,
                 1'b0, 1'b1, 32'h1FF0, 1'b0, 1'b1, 32'h13, 32'h0};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h20, 1'b0, 32'hA5A50001,
                 1'b1, 1'b0, 32'h10,   1'b0, 1'b1, 32'h13, 32'h0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h20, 1'b0, 32'hA5A50001,
                 1'b0, 1'b0, 32'h10,   1'b0, 1'b0, 32'h13, 32'hA5A50001};
    vecs[12] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77,
                 1'b0, 1'b0, 32'h10,   1'b1, 1'b0, 32'h13, 32'hA5A50001};
    vecs[13] = '{1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77,
                 1'b1, 1'b0, 32'h200,  1'b0, 1'b0, 32'h13, 32'hA5A50001};
    vecs[14] = '{1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77,
                 1'b0, 1'b0, 32'h200,  1'b0, 1'b0, 32'h77, 32'hA5A50001};

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_en",   32'(mem_en_o),  32'd0);
    check("rst_mem_wen",  32'(mem_wen_o), 32'd0);
    check("rst_mem_addr", mem_addr_o,     32'd0);
    check("rst_mem_din",  mem_din_o,      32'd0);
    check("rst_im_dout",  im_dout_o,      32'd0);
    check("rst_dm_dout",  dm_dout_o,      32'd0);
    check("rst_im_busy",  32'(im_busy_o), 32'd0);
    check("rst_dm_busy",  32'(dm_busy_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      im_en    = vecs[i].im_en;
      im_addr  = vecs[i].im_addr;
      dm_en    = vecs[i].dm_en;
      dm_wen   = vecs[i].dm_wen;
      dm_din   = vecs[i].dm_din;
      dm_addr  = vecs[i].dm_addr;
      mem_busy = vecs[i].mem_busy;
      mem_dout = vecs[i].mem_dout;
      #1;
      check($sformatf("v%0d_mem_en", i),   32'(mem_en_o),  32'(vecs[i].x_en));
      check($sformatf("v%0d_mem_wen", i),  32'(mem_wen_o), 32'(vecs[i].x_wen));
      check($sformatf("v%0d_mem_addr", i), mem_addr_o,     vecs[i].x_addr);
      check($sformatf("v%0d_im_busy", i),  32'(im_busy_o), 32'(vecs[i].x_imb));
      check($sformatf("v%0d_dm_busy", i),  32'(dm_busy_o), 32'(vecs[i].x_dmb));
      check($sformatf("v%0d_im_dout", i),  im_dout_o,      vecs[i].x_imd);
      check($sformatf("v%0d_dm_dout", i),  dm_dout_o,      vecs[i].x_dmd);
      if (i >= 4 && i <= 7) check($sformatf("v%0d_mem_din", i), mem_din_o, 32'hDEADBEEF);
      tick();
    end

    // Tie from IDLE: dm granted first (also under round-robin, im was granted last), im in dm's RSP
    im_en = 1'b1; im_addr = 32'h104;
    dm_en = 1'b1; dm_wen = 1'b0; dm_addr = 32'h40;
    mem_busy = 1'b0; mem_dout = 32'h0B0B;
    tick();
    check("tie_first_en",   32'(mem_en_o),  32'd1);
    check("tie_first_addr", mem_addr_o,     32'h30);
    check("tie_im_waiting", 32'(im_busy_o), 32'd1);
    tick();
    check("tie_dm_rsp_busy", 32'(dm_busy_o), 32'd0);
    check("tie_dm_dout",     dm_dout_o,      32'h0B0B);
    check("tie_im_still",    32'(im_busy_o), 32'd1);
    dm_en = 1'b0; mem_dout = 32'h1111;
    tick();
    check("tie_second_en",   32'(mem_en_o),  32'd1);
    check("tie_second_wen",  32'(mem_wen_o), 32'd0);
    check("tie_second_addr", mem_addr_o,     32'h104);
    tick();
    check("tie_im_rsp_busy", 32'(im_busy_o), 32'd0);
    check("tie_im_dout",     im_dout_o,      32'h1111);
    im_en = 1'b0;

    // Reset while the memory holds a dm read: abandoned, no response
    dm_en = 1'b1; dm_wen = 1'b0; dm_addr = 32'h80; mem_busy = 1'b1;
    tick();
    check("rstx_granted", 32'(mem_en_o), 32'd1);
    check("rstx_addr",    mem_addr_o,    32'h70);
    rst_n = 1'b0;
    tick();
    check("rstx_mem_en",  32'(mem_en_o), 32'd0);
    check("rstx_dm_dout", dm_dout_o,     32'd0);
    check("rstx_im_dout", im_dout_o,     32'd0);
    rst_n = 1'b1; dm_en = 1'b0; mem_busy = 1'b0;
    tick();
    check("rstx_no_rsp_en",   32'(mem_en_o), 32'd0);
    check("rstx_no_rsp_dout", dm_dout_o,     32'd0);

    // Continuous dm stream with im pending
    im_en = 1'b1; im_addr = 32'h300;
    dm_en = 1'b1; dm_wen = 1'b0; dm_addr = 32'h400; mem_dout = 32'h9;
    im_rsp = 0; dm_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (!im_busy_o) im_rsp++;
      if (!dm_busy_o) dm_rsp++;
    end
    check("stream_im_rsp", 32'(im_rsp), 32'(EXP_IM_RSP));
    check("stream_dm_rsp", 32'(dm_rsp), 32'(EXP_DM_RSP));
    im_en = 1'b0; dm_en = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
